// File: rtl/usb_line_pkg.sv
// Shared types and constants for the full-speed USB bit transmitter.
// Line-state encoding helpers map NRZI levels and line states onto the D+/D- pins.
package usb_line_pkg;

    typedef enum logic [1:0] {
        LS_J   = 2'd0,
        LS_K   = 2'd1,
        LS_SE0 = 2'd2
    } line_state_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_DATA    = 3'd2,
        ST_EOP_SE0 = 3'd3,
        ST_EOP_J   = 3'd4
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE    = 8'h80;
    localparam int         EOP_SE0_BITS = 2;

    // NRZI level 1 idles the bus in J, level 0 is K.
    function automatic line_state_t nrzi_line(input logic lvl);
        if (lvl) begin
            return LS_J;
        end else begin
            return LS_K;
        end
    endfunction

    // Returns {d_plus, d_minus} for a line state.
    function automatic logic [1:0] line_pins(input line_state_t ls);
        case (ls)
            LS_J:    return 2'b10;
            LS_K:    return 2'b01;
            LS_SE0:  return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// Bit stuffer and NRZI encoder: on each bit strobe turns a raw bit (or a forced stuff 0)
// into the next line level, and tells the shifter when the strobe was spent on a stuff bit.
module usb_nrzi_stuffer
    import usb_line_pkg::*;
#(
    parameter int STUFF_LIMIT = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_en,
    input  logic bit_in,
    output logic stuff_now,
    output logic level_next
);

    localparam int OW = $clog2(STUFF_LIMIT + 1);

    logic [OW-1:0] ones_q;
    logic [OW-1:0] ones_d;
    logic          level_q;
    logic          level_d;

    assign stuff_now = (ones_q == OW'(STUFF_LIMIT));

    // Level for the coming bit period: a 0 (stuffed or data) toggles, a 1 holds.
    always_comb begin
        if (stuff_now) begin
            level_next = ~level_q;
        end else if (bit_in) begin
            level_next = level_q;
        end else begin
            level_next = ~level_q;
        end
    end

    // Run-length of transmitted 1s and the current NRZI level.
    always_comb begin
        ones_d  = ones_q;
        level_d = level_q;
        if (clr) begin
            ones_d  = '0;
            level_d = 1'b1;
        end else if (bit_en) begin
            level_d = level_next;
            if (!stuff_now && bit_in) begin
                ones_d = ones_q + OW'(1);
            end else begin
                ones_d = '0;
            end
        end else begin
            ones_d  = ones_q;
            level_d = level_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q  <= '0;
            level_q <= 1'b1;
        end else begin
            ones_q  <= ones_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/usb_bit_tx.sv
// Full-speed USB bit-level transmitter: byte handshake in, SYNC + stuffed NRZI data + EOP out
// on registered D+/D-, one bit every CLKS_PER_BIT clocks.
module usb_bit_tx
    import usb_line_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_oe,
    output logic       busy,
    output logic       underrun
);

    localparam int             PW         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0]  PHASE_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]     EOP_LAST   = 2'(EOP_SE0_BITS - 1);

    tx_state_t     state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bits_left_q, bits_left_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_valid_q, hold_valid_d;
    logic          hold_last_q, hold_last_d;
    logic          cur_last_q, cur_last_d;
    logic          last_acc_q, last_acc_d;
    logic [1:0]    eop_cnt_q, eop_cnt_d;
    logic [1:0]    pins_q, pins_d;
    logic          tx_oe_q, tx_oe_d;
    logic          busy_q, busy_d;
    logic          underrun_q, underrun_d;
    logic          tx_ready_q, tx_ready_d;

    logic          accept, tick, need_byte, stuff_clr;
    logic          bit_en, bit_in, stuff_now, level_next;
    logic          line_upd, line_from_lvl;
    line_state_t   line_fixed;

    assign accept    = tx_valid && tx_ready_q;
    assign tick      = (state_q != ST_IDLE) && (phase_q == PHASE_LAST);
    assign need_byte = (bits_left_q == 4'd0) && ((state_q == ST_SYNC) || !cur_last_q);
    assign stuff_clr = (state_q == ST_EOP_SE0);

    usb_nrzi_stuffer #(
        .STUFF_LIMIT (STUFF_LIMIT)
    ) u_stuffer (
        .clk        (clk),
        .rst        (rst),
        .clr        (stuff_clr),
        .bit_en     (bit_en),
        .bit_in     (bit_in),
        .stuff_now  (stuff_now),
        .level_next (level_next)
    );

    // Handshake, buffering, phase counter and packet FSM.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bits_left_d   = bits_left_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        hold_last_d   = hold_last_q;
        cur_last_d    = cur_last_q;
        last_acc_d    = last_acc_q;
        eop_cnt_d     = eop_cnt_q;
        tx_oe_d       = tx_oe_q;
        busy_d        = busy_q;
        underrun_d    = 1'b0;
        bit_en        = 1'b0;
        bit_in        = 1'b0;
        line_upd      = 1'b0;
        line_from_lvl = 1'b0;
        line_fixed    = LS_J;

        if (state_q == ST_IDLE) begin
            phase_d = '0;
        end else if (phase_q == PHASE_LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PW'(1);
        end

        if (accept) begin
            hold_d       = tx_data;
            hold_valid_d = 1'b1;
            hold_last_d  = tx_last;
            last_acc_d   = last_acc_q || tx_last;
        end else begin
            hold_d = hold_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // First SYNC bit goes out on the very next cycle.
                    state_d       = ST_SYNC;
                    bit_en        = 1'b1;
                    bit_in        = SYNC_BYTE[0];
                    shift_d       = SYNC_BYTE >> 1;
                    bits_left_d   = 4'd7;
                    cur_last_d    = 1'b0;
                    line_upd      = 1'b1;
                    line_from_lvl = 1'b1;
                    tx_oe_d       = 1'b1;
                    busy_d        = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC, ST_DATA: begin
                if (!tick) begin
                    state_d = state_q;
                end else if (need_byte && !hold_valid_q) begin
                    // Starved at a byte boundary: truncate, any pending stuff is dropped.
                    underrun_d = 1'b1;
                    last_acc_d = 1'b1;
                    state_d    = ST_EOP_SE0;
                    eop_cnt_d  = 2'd0;
                    line_upd   = 1'b1;
                    line_fixed = LS_SE0;
                end else if (stuff_now) begin
                    bit_en        = 1'b1;
                    line_upd      = 1'b1;
                    line_from_lvl = 1'b1;
                end else if (bits_left_q != 4'd0) begin
                    bit_en        = 1'b1;
                    bit_in        = shift_q[0];
                    shift_d       = shift_q >> 1;
                    bits_left_d   = bits_left_q - 4'd1;
                    line_upd      = 1'b1;
                    line_from_lvl = 1'b1;
                end else if (need_byte) begin
                    bit_en        = 1'b1;
                    bit_in        = hold_q[0];
                    shift_d       = hold_q >> 1;
                    bits_left_d   = 4'd7;
                    cur_last_d    = hold_last_q;
                    hold_valid_d  = 1'b0;
                    state_d       = ST_DATA;
                    line_upd      = 1'b1;
                    line_from_lvl = 1'b1;
                end else begin
                    state_d    = ST_EOP_SE0;
                    eop_cnt_d  = 2'd0;
                    line_upd   = 1'b1;
                    line_fixed = LS_SE0;
                end
            end
            ST_EOP_SE0: begin
                if (!tick) begin
                    state_d = ST_EOP_SE0;
                end else if (eop_cnt_q == EOP_LAST) begin
                    state_d    = ST_EOP_J;
                    line_upd   = 1'b1;
                    line_fixed = LS_J;
                end else begin
                    eop_cnt_d = eop_cnt_q + 2'd1;
                end
            end
            ST_EOP_J: begin
                if (tick) begin
                    state_d    = ST_IDLE;
                    tx_oe_d    = 1'b0;
                    busy_d     = 1'b0;
                    last_acc_d = 1'b0;
                end else begin
                    state_d = ST_EOP_J;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_oe_d    = 1'b0;
                busy_d     = 1'b0;
                last_acc_d = 1'b0;
                line_upd   = 1'b1;
                line_fixed = LS_J;
            end
        endcase

        tx_ready_d = !hold_valid_d && !last_acc_d;
    end

    // Next D+/D- pin pair; kept apart from the FSM so the stuffer path stays acyclic.
    always_comb begin
        if (!line_upd) begin
            pins_d = pins_q;
        end else if (line_from_lvl) begin
            pins_d = line_pins(nrzi_line(level_next));
        end else begin
            pins_d = line_pins(line_fixed);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            shift_q      <= 8'h00;
            bits_left_q  <= 4'd0;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            cur_last_q   <= 1'b0;
            last_acc_q   <= 1'b0;
            eop_cnt_q    <= 2'd0;
            pins_q       <= 2'b10;
            tx_oe_q      <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
            tx_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            shift_q      <= shift_d;
            bits_left_q  <= bits_left_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            hold_last_q  <= hold_last_d;
            cur_last_q   <= cur_last_d;
            last_acc_q   <= last_acc_d;
            eop_cnt_q    <= eop_cnt_d;
            pins_q       <= pins_d;
            tx_oe_q      <= tx_oe_d;
            busy_q       <= busy_d;
            underrun_q   <= underrun_d;
            tx_ready_q   <= tx_ready_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign d_plus   = pins_q[1];
    assign d_minus  = pins_q[0];
    assign tx_oe    = tx_oe_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_usb_bit_tx.sv
// Self-checking bench for usb_bit_tx: packet vectors drive the byte handshake while a
// scoreboard of expected line symbols (built by an independent NRZI/stuffing model) is checked.
module tb_usb_bit_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_oe;
    logic       busy;
    logic       underrun;

    always #10 clk = ~clk;

    usb_bit_tx #(
        .CLKS_PER_BIT (CPB),
        .STUFF_LIMIT  (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .tx_oe    (tx_oe),
        .busy     (busy),
        .underrun (underrun)
    );

    typedef struct {
        int          n;
        logic [31:0] bytes;
        logic        last;
        int          periods;
        int          unr;
    } vec_t;

    vec_t       vecs [8];
    vec_t       v_abort;
    vec_t       v_after;
    logic [1:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc_oe;
    int         unr_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_sym(input logic [1:0] s);
        for (int k = 0; k < CPB; k++) exp_q.push_back(s);
    endtask

    // Expected line symbols: stuff inserted right after every sixth consecutive 1.
    task automatic build_expected(input vec_t v);
        logic       lvl;
        int         ones;
        logic [7:0] sb;
        lvl  = 1'b1;
        ones = 0;
        for (int i = -1; i < v.n; i++) begin
            if (i < 0) sb = 8'h80;
            else       sb = v.bytes[8*i +: 8];
            for (int j = 0; j < 8; j++) begin
                if (sb[j]) begin
                    ones++;
                end else begin
                    lvl  = ~lvl;
                    ones = 0;
                end
                push_sym(lvl ? 2'b10 : 2'b01);
                if (ones == 6) begin
                    lvl  = ~lvl;
                    ones = 0;
                    push_sym(lvl ? 2'b10 : 2'b01);
                end
            end
        end
        push_sym(2'b00);
        push_sym(2'b00);
        push_sym(2'b10);
    endtask

    // One clock: note whether a byte is taken at this edge, then sample #1 after it.
    task automatic tick(output logic acc);
        logic [1:0] e;
        acc = tx_valid && tx_ready;
        @(posedge clk);
        #1;
        if (tx_oe) begin
            cyc_oe++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL line_extra: got {d+,d-}=%0b with tx_oe=1, expected no further bit", {d_plus, d_minus});
            end else begin
                e = exp_q.pop_front();
                check("line_symbol", {d_plus, d_minus}, e);
            end
        end else begin
            check("idle_line_j", {d_plus, d_minus}, 2'b10);
        end
        if (underrun) unr_seen++;
    endtask

    task automatic run_packet(input vec_t v, input int abort_at);
        int   idx;
        int   cyc;
        int   t_first;
        logic acc;
        logic done;
        logic last_taken;
        logic ready_checked;
        idx           = 0;
        cyc           = 0;
        t_first       = -1;
        done          = 1'b0;
        last_taken    = 1'b0;
        ready_checked = 1'b0;
        exp_q.delete();
        build_expected(v);
        cyc_oe   = 0;
        unr_seen = 0;
        tx_valid = 1'b1;
        tx_data  = v.bytes[7:0];
        tx_last  = v.last && (v.n == 1);
        while (!done && cyc < 2000) begin
            tick(acc);
            cyc++;
            if (acc) begin
                if (idx == 0) begin
                    t_first = cyc;
                    check("start_tx_oe", tx_oe, 1'b1);
                    check("start_busy", busy, 1'b1);
                end else if (idx == 1) begin
                    check("second_accept_early", (cyc - t_first) < 15 * CPB, 1'b1);
                end else begin
                    check("later_accept_in_packet", tx_oe, 1'b1);
                end
                if (v.last && idx == v.n - 1) last_taken = 1'b1;
                idx++;
                if (idx < v.n) begin
                    tx_data = v.bytes[8*idx +: 8];
                    tx_last = v.last && (idx == v.n - 1);
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'h00;
                    tx_last  = 1'b1;
                end
            end else if (last_taken && !ready_checked && tx_oe) begin
                ready_checked = 1'b1;
                check("ready_low_after_last", tx_ready, 1'b0);
            end
            if (abort_at > 0 && t_first >= 0 && (cyc - t_first) == abort_at) begin
                rst = 1'b1;
                tick(acc);
                check("rst_mid_d_plus", d_plus, 1'b1);
                check("rst_mid_d_minus", d_minus, 1'b0);
                check("rst_mid_tx_oe", tx_oe, 1'b0);
                check("rst_mid_busy", busy, 1'b0);
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (t_first >= 0 && !tx_oe) begin
                done = 1'b1;
                check("end_busy_low", busy, 1'b0);
                check("end_ready_high", tx_ready, 1'b1);
                check("end_symbols_left", exp_q.size(), 0);
                check("tx_oe_periods", cyc_oe, v.periods * CPB);
                check("underrun_pulses", unr_seen, v.unr);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL packet_timeout: got no end of packet after %0d cycles, expected tx_oe to drop", cyc);
        end
    endtask

    initial begin
        logic acc;
        vecs[0] = '{n: 1, bytes: 32'h0000_0000, last: 1'b1, periods: 19, unr: 0};
        vecs[1] = '{n: 1, bytes: 32'h0000_00FF, last: 1'b1, periods: 20, unr: 0};
        vecs[2] = '{n: 2, bytes: 32'h0000_3CA5, last: 1'b1, periods: 27, unr: 0};
        vecs[3] = '{n: 3, bytes: 32'h0003_FF7E, last: 1'b1, periods: 37, unr: 0};
        vecs[4] = '{n: 2, bytes: 32'h0000_03F0, last: 1'b1, periods: 28, unr: 0};
        vecs[5] = '{n: 2, bytes: 32'h0000_00FC, last: 1'b1, periods: 28, unr: 0};
        vecs[6] = '{n: 1, bytes: 32'h0000_0001, last: 1'b0, periods: 19, unr: 1};
        vecs[7] = '{n: 2, bytes: 32'h0000_FFFF, last: 1'b1, periods: 29, unr: 0};
        v_abort = '{n: 1, bytes: 32'h0000_0055, last: 1'b1, periods: 19, unr: 0};
        v_after = '{n: 1, bytes: 32'h0000_00FC, last: 1'b1, periods: 20, unr: 0};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_d_plus", d_plus, 1'b1);
        check("reset_d_minus", d_minus, 1'b0);
        check("reset_tx_oe", tx_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_underrun", underrun, 1'b0);
        check("reset_ready_low", tx_ready, 1'b0);
        rst = 1'b0;
        tick(acc);
        check("ready_after_reset", tx_ready, 1'b1);

        for (int i = 0; i < 8; i++) run_packet(vecs[i], 0);

        run_packet(v_abort, 8 * CPB + 10);
        tick(acc);
        run_packet(v_after, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
